operand_collector_unit: RTL

//  One collector-unit slot of the operand collector. Sits directly downstream of the

---
 rtl/operand_collector_unit_pkg.sv | 18 +
 rtl/operand_collector_unit_slot.sv | 59 +++++
 rtl/operand_collector_unit.sv | 114 +++++++++++
 3 files changed

// File: rtl/operand_collector_unit_pkg.sv
// operand_collector_unit_pkg: shared encodings for the operand collector slot.
package operand_collector_unit_pkg;
    localparam int NUM_OPERAND = 3;
    localparam int DEPTH_WARP  = 3;

    typedef enum logic [1:0] {
        OP_EMPTY   = 2'd0,
        OP_PENDING = 2'd1,
        OP_ISSUED  = 2'd2,
        OP_READY   = 2'd3
    } op_status_e;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_OUTPUT  = 2'd2
    } unit_state_e;
endpackage

// File: rtl/operand_collector_unit_slot.sv
// operand_collector_unit_slot: status tracking and data capture for one source operand.
module operand_collector_unit_slot
    import operand_collector_unit_pkg::*;
#(
    parameter int NUM_THREAD = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load_i,
    input  logic                    clear_i,
    input  logic                    need_i,
    input  logic                    isvec_i,
    output logic                    req_valid_o,
    input  logic                    req_ready_i,
    input  logic                    rsp_valid_i,
    input  logic [NUM_THREAD*32-1:0] rsp_data_i,
    output logic                    ready_o,
    output logic [NUM_THREAD*32-1:0] data_o
);
    op_status_e               status_q, status_d;
    logic                     req_q, req_d;
    logic [NUM_THREAD*32-1:0] data_q, data_d;

    always_comb begin
        status_d = status_q;
        req_d    = req_q;
        data_d   = data_q;
        if (load_i) begin
            status_d = need_i ? OP_PENDING : OP_READY;
            req_d    = need_i;
            data_d   = '0;
        end else if (clear_i) begin
            status_d = OP_EMPTY;
        end else if (status_q == OP_PENDING && req_q && req_ready_i) begin
            status_d = OP_ISSUED;
            req_d    = 1'b0;
        end else if (status_q == OP_ISSUED && rsp_valid_i) begin
            // scalar reads only return lane 0; broadcast it across the vector
            status_d = OP_READY;
            data_d   = isvec_i ? rsp_data_i : {NUM_THREAD{rsp_data_i[31:0]}};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= OP_EMPTY;
            req_q    <= 1'b0;
            data_q   <= '0;
        end else begin
            status_q <= status_d;
            req_q    <= req_d;
            data_q   <= data_d;
        end
    end

    assign req_valid_o = req_q;
    assign ready_o     = (status_q == OP_READY);
    assign data_o      = data_q;
endmodule

// File: rtl/operand_collector_unit.sv
// operand_collector_unit: one collector slot - accepts an instruction, reads up to
// three operands from the register files, then hands the full set to dispatch.
module operand_collector_unit
    import operand_collector_unit_pkg::*;
#(
    parameter int NUM_THREAD = 8,
    parameter int NUM_BANK   = 4,
    parameter int CTRL_W     = 128,
    parameter int ADDR_W     = 10,
    parameter int WID_W      = DEPTH_WARP,
    parameter int BANK_W     = $clog2(NUM_BANK),
    parameter int DW         = NUM_THREAD * 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [WID_W-1:0]              in_wid_i,
    input  logic [CTRL_W-1:0]             in_ctrl_i,
    input  logic [NUM_OPERAND-1:0]        in_need_i,
    input  logic [NUM_OPERAND-1:0]        in_isvec_i,
    input  logic [NUM_OPERAND*ADDR_W-1:0] in_addr_i,
    output logic [NUM_OPERAND-1:0]        rd_req_valid_o,
    output logic [NUM_OPERAND-1:0]        rd_req_isvec_o,
    output logic [NUM_OPERAND*ADDR_W-1:0] rd_req_addr_o,
    output logic [NUM_OPERAND*BANK_W-1:0] rd_req_bank_o,
    input  logic [NUM_OPERAND-1:0]        rd_req_ready_i,
    input  logic [NUM_OPERAND-1:0]        rd_rsp_valid_i,
    input  logic [NUM_OPERAND*DW-1:0]     rd_rsp_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [WID_W-1:0]              out_wid_o,
    output logic [CTRL_W-1:0]             out_ctrl_o,
    output logic [NUM_OPERAND*DW-1:0]     out_op_o,
    output logic                          busy_o,
    output logic [WID_W-1:0]              busy_wid_o
);
    unit_state_e                   state_q, state_d;
    logic                          out_valid_q, out_valid_d;
    logic [WID_W-1:0]              wid_q;
    logic [CTRL_W-1:0]             ctrl_q;
    logic [NUM_OPERAND*ADDR_W-1:0] addr_q;
    logic [NUM_OPERAND-1:0]        isvec_q;
    logic [NUM_OPERAND-1:0]        op_ready;
    logic                          accept, done;

    assign accept = in_valid_i && (state_q == S_IDLE);
    assign done   = out_valid_q && out_ready_i;

    // out_valid is registered, so a no-operand instruction sees it one cycle after entering OUTPUT
    always_comb begin
        state_d     = state_q;
        out_valid_d = 1'b0;
        case (state_q)
            S_IDLE: if (accept) state_d = (in_need_i == '0) ? S_OUTPUT : S_COLLECT;
            S_COLLECT: if (&op_ready) begin
                state_d     = S_OUTPUT;
                out_valid_d = 1'b1;
            end
            S_OUTPUT: begin
                state_d     = done ? S_IDLE : S_OUTPUT;
                out_valid_d = !done;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            wid_q       <= '0;
            ctrl_q      <= '0;
            addr_q      <= '0;
            isvec_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            if (accept) begin
                wid_q   <= in_wid_i;
                ctrl_q  <= in_ctrl_i;
                addr_q  <= in_addr_i;
                isvec_q <= in_isvec_i;
            end
        end
    end

    for (genvar n = 0; n < NUM_OPERAND; n++) begin : g_op
        operand_collector_unit_slot #(.NUM_THREAD(NUM_THREAD)) u_slot (
            .clk         (clk),
            .rst_n       (rst_n),
            .load_i      (accept),
            .clear_i     (done),
            .need_i      (in_need_i[n]),
            .isvec_i     (isvec_q[n]),
            .req_valid_o (rd_req_valid_o[n]),
            .req_ready_i (rd_req_ready_i[n]),
            .rsp_valid_i (rd_rsp_valid_i[n]),
            .rsp_data_i  (rd_rsp_data_i[n*DW +: DW]),
            .ready_o     (op_ready[n]),
            .data_o      (out_op_o[n*DW +: DW])
        );
        assign rd_req_bank_o[n*BANK_W +: BANK_W] = addr_q[n*ADDR_W +: BANK_W];
    end

    assign in_ready_o     = (state_q == S_IDLE);
    assign busy_o         = (state_q != S_IDLE);
    assign busy_wid_o     = busy_o ? wid_q : '0;
    assign out_valid_o    = out_valid_q;
    assign out_wid_o      = wid_q;
    assign out_ctrl_o     = ctrl_q;
    assign rd_req_isvec_o = isvec_q;
    assign rd_req_addr_o  = addr_q;
endmodule
